// File: rtl/pong_match_controller_pkg.sv
// Shared types and defaults for the Pong match controller slice.
package pong_match_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_POINT  = 3'd3,
    ST_PAUSED = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BOUNCE_NONE   = 2'd0,
    BOUNCE_PADDLE = 2'd1,
    BOUNCE_WALL   = 2'd2,
    BOUNCE_SCORE  = 2'd3
  } bounce_t;

  localparam int   POS_W            = 10;
  localparam int   DEF_SCREEN_X     = 640;
  localparam int   DEF_WIN_SCORE    = 9;
  localparam int   DEF_SERVE_FRAMES = 60;
  localparam int   DEF_SCORE_W      = 4;
  localparam logic PLAYER_1         = 1'b0;
  localparam logic PLAYER_2         = 1'b1;

  // Ball in the right half means it left player 2's side, so player 1 scored.
  function automatic logic scorer_of(input logic [POS_W-1:0] x,
                                     input logic [POS_W-1:0] half_x);
    return (x >= half_x) ? PLAYER_1 : PLAYER_2;
  endfunction

endpackage

// File: rtl/pong_match_controller_if.sv
// Link between collision logic / ball FSM and the match controller.
interface pong_match_controller_if;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x;
  logic       ball_hold;
  logic       ball_run;
  logic       serve_dir;

  modport master (
    input  bounce,
    input  ball_pos_x,
    output ball_hold,
    output ball_run,
    output serve_dir
  );

  modport slave (
    output bounce,
    output ball_pos_x,
    input  ball_hold,
    input  ball_run,
    input  serve_dir
  );
endinterface

// File: rtl/pong_match_controller_serve_timer.sv
// Loadable frame down-counter that saturates at zero; zero flag is combinational off the count.
module pong_match_controller_serve_timer
  import pong_match_controller_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pong_match_controller.sv
// Match-level sequencer: serve delay, play/pause, point scoring and winner declaration.
//  state  | meaning
//  IDLE   | waiting for start, ball held
//  SERVE  | ball held for SERVE_FRAMES frames before play
//  PLAY   | ball running, watching for score events and pause
//  POINT  | one cycle: award point, decide SERVE or OVER
//  PAUSED | ball frozen, waiting for next pause edge
//  OVER   | match ended, winner shown until start
module pong_match_controller
  import pong_match_controller_pkg::*;
#(
  parameter int SCREEN_X     = DEF_SCREEN_X,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 frame_tick,
  pong_match_controller_if.master bus,
  output logic [SCORE_W-1:0]   score_player_1,
  output logic [SCORE_W-1:0]   score_player_2,
  output logic                 game_over,
  output logic                 winner,
  output logic [2:0]           state_dbg
);

  localparam int               CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [POS_W-1:0] HALF_X  = POS_W'(SCREEN_X / 2);
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] LOAD_V  = CNT_W'(SERVE_FRAMES);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [SCORE_W-1:0] new_score;
  logic               scorer_q, scorer_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               hold_q, hold_d;
  logic               run_q, run_d;
  logic               pause_q;
  logic               pause_edge;
  logic               timer_load;
  logic               timer_tick;
  logic               timer_zero;

  pong_match_controller_serve_timer #(.CNT_W(CNT_W)) u_serve_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (LOAD_V),
    .tick     (timer_tick),
    .zero     (timer_zero)
  );

  assign pause_edge = pause & ~pause_q;

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    new_score   = '0;
    scorer_d    = scorer_q;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    timer_load  = 1'b0;
    timer_tick  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b0;
          game_over_d = 1'b0;
          timer_load  = 1'b1;
        end
      end
      ST_SERVE: begin
        timer_tick = frame_tick;
        // A score code left over from the previous rally must clear before play resumes.
        if (timer_zero && (bus.bounce != BOUNCE_SCORE)) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.bounce == BOUNCE_SCORE) begin
          state_d  = ST_POINT;
          scorer_d = scorer_of(bus.ball_pos_x, HALF_X);
        end else if (pause_edge) begin
          state_d = ST_PAUSED;
        end
      end
      ST_POINT: begin
        if (scorer_q == PLAYER_1) begin
          new_score = score1_q + SCORE_W'(1);
          score1_d  = new_score;
        end else begin
          new_score = score2_q + SCORE_W'(1);
          score2_d  = new_score;
        end
        if (new_score == WIN_V) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
          winner_d    = scorer_q;
        end else begin
          state_d     = ST_SERVE;
          serve_dir_d = ~scorer_q;
          timer_load  = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (pause_edge) begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    hold_d = !((state_d == ST_PLAY) || (state_d == ST_PAUSED));
    run_d  = (state_d == ST_PLAY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      score1_q    <= '0;
      score2_q    <= '0;
      scorer_q    <= PLAYER_1;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      hold_q      <= 1'b1;
      run_q       <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      scorer_q    <= scorer_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      hold_q      <= hold_d;
      run_q       <= run_d;
      pause_q     <= pause;
    end
  end

  assign bus.ball_hold  = hold_q;
  assign bus.ball_run   = run_q;
  assign bus.serve_dir  = serve_dir_q;
  assign score_player_1 = score1_q;
  assign score_player_2 = score2_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller with hand-computed expectations.
module tb_pong_match_controller;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       pause;
  logic       frame_tick;
  logic [3:0] score_player_1;
  logic [3:0] score_player_2;
  logic       game_over;
  logic       winner;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  pong_match_controller_if bus ();

  pong_match_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .pause          (pause),
    .frame_tick     (frame_tick),
    .bus            (bus),
    .score_player_1 (score_player_1),
    .score_player_2 (score_player_2),
    .game_over      (game_over),
    .winner         (winner),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic score_point(input logic [9:0] x);
    bus.bounce     = 2'd3;
    bus.ball_pos_x = x;
    step();
    bus.bounce = 2'd0;
    step();
  endtask

  initial begin
    clock          = 1'b0;
    reset_n        = 1'b0;
    start          = 1'b0;
    pause          = 1'b0;
    frame_tick     = 1'b0;
    bus.bounce     = 2'd0;
    bus.ball_pos_x = 10'd0;
    step();
    step();
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_hold", 32'(bus.ball_hold), 1);
    chk("rst_run", 32'(bus.ball_run), 0);
    chk("rst_dir", 32'(bus.serve_dir), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_s1", 32'(score_player_1), 0);
    reset_n = 1'b1;
    step();
    chk("idle_no_start", 32'(state_dbg), 0);

    // start, then exactly 60 ticks; PLAY one cycle after the last tick
    start = 1'b1;
    step();
    start = 1'b0;
    chk("serve_entry", 32'(state_dbg), 1);
    chk("serve_hold", 32'(bus.ball_hold), 1);
    frame_ticks(59);
    chk("serve_59", 32'(state_dbg), 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("serve_60_edge", 32'(state_dbg), 1);
    step();
    chk("play_entry", 32'(state_dbg), 2);
    chk("play_run", 32'(bus.ball_run), 1);
    chk("play_hold", 32'(bus.ball_hold), 0);

    // bounce=3 at x=630 held 5 cycles: single point for player 1
    bus.bounce     = 2'd3;
    bus.ball_pos_x = 10'd630;
    step();
    chk("point_state", 32'(state_dbg), 3);
    chk("point_hold", 32'(bus.ball_hold), 1);
    chk("point_s1_pre", 32'(score_player_1), 0);
    step();
    chk("after_point_serve", 32'(state_dbg), 1);
    chk("after_point_s1", 32'(score_player_1), 1);
    step();
    step();
    step();
    chk("held_s1", 32'(score_player_1), 1);
    chk("held_s2", 32'(score_player_2), 0);
    chk("held_state", 32'(state_dbg), 1);
    chk("held_dir", 32'(bus.serve_dir), 1);
    bus.bounce = 2'd0;

    // stale score code after count reaches zero blocks PLAY
    frame_ticks(59);
    frame_tick = 1'b1;
    bus.bounce = 2'd3;
    step();
    frame_tick = 1'b0;
    step();
    step();
    chk("stale_block", 32'(state_dbg), 1);
    bus.bounce = 2'd0;
    step();
    chk("stale_clear_play", 32'(state_dbg), 2);

    // pause rising with bounce=3 at x=2: point wins
    pause          = 1'b1;
    bus.bounce     = 2'd3;
    bus.ball_pos_x = 10'd2;
    step();
    bus.bounce = 2'd0;
    chk("pp_point", 32'(state_dbg), 3);
    step();
    chk("pp_serve", 32'(state_dbg), 1);
    chk("pp_s2", 32'(score_player_2), 1);
    chk("pp_s1", 32'(score_player_1), 1);
    chk("pp_dir", 32'(bus.serve_dir), 0);
    pause = 1'b0;
    frame_ticks(60);
    chk("pp_play", 32'(state_dbg), 2);

    // pause pulse -> PAUSED, score event ignored, second pulse -> PLAY
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("paused_state", 32'(state_dbg), 4);
    chk("paused_hold", 32'(bus.ball_hold), 0);
    chk("paused_run", 32'(bus.ball_run), 0);
    bus.bounce     = 2'd3;
    bus.ball_pos_x = 10'd630;
    frame_tick     = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    bus.bounce = 2'd0;
    chk("paused_ignore_state", 32'(state_dbg), 4);
    chk("paused_ignore_s1", 32'(score_player_1), 1);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("resume_state", 32'(state_dbg), 2);
    chk("resume_run", 32'(bus.ball_run), 1);

    // reach 3:2 then reset mid-PLAY
    score_point(10'd630);
    frame_ticks(60);
    score_point(10'd630);
    frame_ticks(60);
    score_point(10'd100);
    frame_ticks(60);
    chk("pre_rst_s1", 32'(score_player_1), 3);
    chk("pre_rst_s2", 32'(score_player_2), 2);
    chk("pre_rst_state", 32'(state_dbg), 2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_dbg), 0);
    chk("async_rst_s1", 32'(score_player_1), 0);
    chk("async_rst_hold", 32'(bus.ball_hold), 1);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_state", 32'(state_dbg), 0);
    chk("post_rst_s2", 32'(score_player_2), 0);
    chk("post_rst_run", 32'(bus.ball_run), 0);

    // 8:0 then winning point for player 1
    start = 1'b1;
    step();
    start = 1'b0;
    frame_ticks(60);
    for (int p = 0; p < 8; p++) begin
      score_point(10'd630);
      frame_ticks(60);
    end
    chk("eight_s1", 32'(score_player_1), 8);
    chk("eight_state", 32'(state_dbg), 2);
    score_point(10'd630);
    chk("over_state", 32'(state_dbg), 5);
    chk("over_flag", 32'(game_over), 1);
    chk("over_winner", 32'(winner), 0);
    chk("over_s1", 32'(score_player_1), 9);
    chk("over_hold", 32'(bus.ball_hold), 1);
    bus.bounce = 2'd3;
    frame_tick = 1'b1;
    step();
    step();
    step();
    bus.bounce = 2'd0;
    frame_tick = 1'b0;
    chk("over_stuck_s1", 32'(score_player_1), 9);
    chk("over_stuck_state", 32'(state_dbg), 5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_state", 32'(state_dbg), 1);
    chk("restart_s1", 32'(score_player_1), 0);
    chk("restart_over", 32'(game_over), 0);
    chk("restart_dir", 32'(bus.serve_dir), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
